// File: rtl/ysyx_24090012_axi_rd_xbar.sv
// ysyx_24090012_axi_rd_xbar
// One-master / two-slave AXI4-Lite read crossbar. Slave 0 is the CLINT, slave 1 is
// main memory. One read is in flight at a time; unmapped addresses are answered
// locally with DECERR, and a slave that stalls past TIMEOUT cycles gets a local SLVERR.
module ysyx_24090012_axi_rd_xbar #(
  parameter logic [31:0] S0_BASE = 32'h0200_0000,
  parameter logic [31:0] S0_MASK = 32'hFFFF_0000,
  parameter logic [31:0] S1_BASE = 32'h8000_0000,
  parameter logic [31:0] S1_MASK = 32'hF800_0000,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rst,
  // master (LSU) side
  input  logic        m_arvalid,
  output logic        m_arready,
  input  logic [31:0] m_araddr,
  output logic        m_rvalid,
  input  logic        m_rready,
  output logic [31:0] m_rdata,
  output logic [1:0]  m_rresp,
  // slave 0 (CLINT)
  output logic        s0_arvalid,
  input  logic        s0_arready,
  output logic [31:0] s0_araddr,
  input  logic        s0_rvalid,
  output logic        s0_rready,
  input  logic [31:0] s0_rdata,
  input  logic [1:0]  s0_rresp,
  // slave 1 (memory)
  output logic        s1_arvalid,
  input  logic        s1_arready,
  output logic [31:0] s1_araddr,
  input  logic        s1_rvalid,
  output logic        s1_rready,
  input  logic [31:0] s1_rdata,
  input  logic [1:0]  s1_rresp
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // A TIMEOUT of zero turns the stall watchdog off entirely.
  localparam bit          TMO_EN   = (TIMEOUT != 32'd0);
  localparam logic [15:0] TMO_LAST = TMO_EN ? 16'(TIMEOUT - 32'd1) : 16'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2,
    ERR  = 2'd3
  } state_t;

  // Address window decode helpers.
  function automatic logic hit_s0(input logic [31:0] addr);
    return (addr & S0_MASK) == S0_BASE;
  endfunction

  function automatic logic hit_s1(input logic [31:0] addr);
    return (addr & S1_MASK) == S1_BASE;
  endfunction

  state_t      state_r, state_s;
  logic [31:0] addr_r, addr_s;
  logic        sel_r, sel_s;
  logic [15:0] tmo_cnt_r, tmo_cnt_s;
  logic [1:0]  err_resp_r, err_resp_s;

  // Signals of whichever slave the current transaction targets.
  logic        sel_arready_s;
  logic        sel_rvalid_s;
  logic [31:0] sel_rdata_s;
  logic [1:0]  sel_rresp_s;
  logic        tmo_hit_s;

  // Both slaves see the latched address; only the selected one gets arvalid.
  assign s0_araddr = addr_r;
  assign s1_araddr = addr_r;

  assign sel_arready_s = sel_r ? s1_arready : s0_arready;
  assign sel_rvalid_s  = sel_r ? s1_rvalid  : s0_rvalid;
  assign sel_rdata_s   = sel_r ? s1_rdata   : s0_rdata;
  assign sel_rresp_s   = sel_r ? s1_rresp   : s0_rresp;
  assign tmo_hit_s     = TMO_EN && (tmo_cnt_r == TMO_LAST);

  // State and transaction registers; reset abandons any transfer in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      addr_r     <= 32'd0;
      sel_r      <= 1'b0;
      tmo_cnt_r  <= 16'd0;
      err_resp_r <= RESP_OKAY;
    end else begin
      state_r    <= state_s;
      addr_r     <= addr_s;
      sel_r      <= sel_s;
      tmo_cnt_r  <= tmo_cnt_s;
      err_resp_r <= err_resp_s;
    end
  end

  // Next-state logic and all channel outputs, decoded from the current state.
  always_comb begin
    state_s    = state_r;
    addr_s     = addr_r;
    sel_s      = sel_r;
    tmo_cnt_s  = tmo_cnt_r;
    err_resp_s = err_resp_r;
    m_arready  = 1'b0;
    m_rvalid   = 1'b0;
    m_rdata    = 32'd0;
    m_rresp    = RESP_OKAY;
    s0_arvalid = 1'b0;
    s1_arvalid = 1'b0;
    s0_rready  = 1'b0;
    s1_rready  = 1'b0;

    case (state_r)
      IDLE: begin
        m_arready = 1'b1;
        if (m_arvalid) begin
          addr_s    = m_araddr;
          tmo_cnt_s = 16'd0;
          // CLINT is checked first so it wins if the windows ever overlap.
          if (hit_s0(m_araddr)) begin
            sel_s   = 1'b0;
            state_s = SEND;
          end else if (hit_s1(m_araddr)) begin
            sel_s   = 1'b1;
            state_s = SEND;
          end else begin
            err_resp_s = RESP_DECERR;
            state_s    = ERR;
          end
        end else begin
          state_s = IDLE;
        end
      end

      SEND: begin
        tmo_cnt_s  = tmo_cnt_r + 16'd1;
        s0_arvalid = ~sel_r;
        s1_arvalid = sel_r;
        // An address accepted on the last allowed cycle still proceeds.
        if (sel_arready_s) begin
          state_s = WAIT;
        end else if (tmo_hit_s) begin
          err_resp_s = RESP_SLVERR;
          state_s    = ERR;
        end else begin
          state_s = SEND;
        end
      end

      WAIT: begin
        tmo_cnt_s = tmo_cnt_r + 16'd1;
        m_rvalid  = sel_rvalid_s;
        if (sel_rvalid_s) begin
          m_rdata = sel_rdata_s;
          m_rresp = sel_rresp_s;
        end else begin
          m_rdata = 32'd0;
          m_rresp = RESP_OKAY;
        end
        // The CLINT drops its read state on rready alone, so rready is
        // only ever raised alongside the slave's own rvalid.
        s0_rready = ~sel_r & m_rready & s0_rvalid;
        s1_rready = sel_r & m_rready & s1_rvalid;
        if (sel_rvalid_s && m_rready) begin
          state_s = IDLE;
        end else if (tmo_hit_s) begin
          err_resp_s = RESP_SLVERR;
          state_s    = ERR;
        end else begin
          state_s = WAIT;
        end
      end

      ERR: begin
        m_rvalid = 1'b1;
        m_rdata  = 32'd0;
        m_rresp  = err_resp_r;
        if (m_rready) begin
          state_s = IDLE;
        end else begin
          state_s = ERR;
        end
      end

      default: begin
        state_s = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ysyx_24090012_axi_rd_xbar.sv
// Directed, table-driven bench for ysyx_24090012_axi_rd_xbar with a CLINT model on
// slave 0 and a latency-configurable memory model on slave 1.
module tb_ysyx_24090012_axi_rd_xbar;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m_arvalid = 1'b0;
  logic        m_arready;
  logic [31:0] m_araddr = 32'd0;
  logic        m_rvalid;
  logic        m_rready = 1'b0;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        s0_arvalid, s0_arready, s0_rvalid, s0_rready;
  logic [31:0] s0_araddr, s0_rdata;
  logic [1:0]  s0_rresp;
  logic        s1_arvalid, s1_arready, s1_rvalid, s1_rready;
  logic [31:0] s1_araddr, s1_rdata;
  logic [1:0]  s1_rresp;

  int n_cmp = 0;
  int n_bad = 0;

  ysyx_24090012_axi_rd_xbar #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .s0_arvalid(s0_arvalid), .s0_arready(s0_arready), .s0_araddr(s0_araddr),
    .s0_rvalid(s0_rvalid), .s0_rready(s0_rready), .s0_rdata(s0_rdata), .s0_rresp(s0_rresp),
    .s1_arvalid(s1_arvalid), .s1_arready(s1_arready), .s1_araddr(s1_araddr),
    .s1_rvalid(s1_rvalid), .s1_rready(s1_rready), .s1_rdata(s1_rdata), .s1_rresp(s1_rresp)
  );

  always #5 clk = ~clk;

  // ---------------- CLINT model: one-cycle read latency, data = mtime >> 6 ----------
  logic [63:0] mtime = 64'd0;
  logic [63:0] mtime_sh;
  logic        c_busy;
  logic [31:0] c_data;
  assign mtime_sh   = mtime >> 6;
  assign s0_arready = ~c_busy;
  assign s0_rvalid  = c_busy;
  assign s0_rdata   = c_busy ? c_data : 32'd0;
  assign s0_rresp   = 2'b00;

  // CLINT read state; leaves it on rready alone.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      c_busy <= 1'b0;
      c_data <= 32'd0;
    end else if (!c_busy && s0_arvalid) begin
      c_busy <= 1'b1;
      c_data <= (s0_araddr[3:2] == 2'b11) ? mtime_sh[63:32] : mtime_sh[31:0];
    end else if (s0_rready) begin
      c_busy <= 1'b0;
    end
  end

  // ---------------- memory model: rvalid in the 5th cycle after AR accept -------------
  logic [31:0] mem_data = 32'd0;
  logic [1:0]  mem_resp = 2'b00;
  int          mem_ar_dly = 0;
  logic        mem_hang = 1'b0;
  logic        mem_clr = 1'b0;
  logic        m_busy;
  logic [2:0]  m_cnt;
  int          m_ar_wait;
  assign s1_arready = ~m_busy && (m_ar_wait >= mem_ar_dly);
  assign s1_rvalid  = m_busy && (m_cnt == 3'd0) && !mem_hang;
  assign s1_rdata   = s1_rvalid ? mem_data : 32'd0;
  assign s1_rresp   = s1_rvalid ? mem_resp : 2'b00;

  // Memory read state with optional AR back-pressure and a hang mode.
  always @(posedge clk or posedge rst) begin
    if (rst || mem_clr) begin
      m_busy    <= 1'b0;
      m_cnt     <= 3'd0;
      m_ar_wait <= 0;
    end else if (!m_busy) begin
      if (s1_arvalid && s1_arready) begin
        m_busy    <= 1'b1;
        m_cnt     <= 3'd4;
        m_ar_wait <= 0;
      end else if (s1_arvalid) begin
        m_ar_wait <= m_ar_wait + 1;
      end
    end else begin
      if (m_cnt != 3'd0) m_cnt <= m_cnt - 3'd1;
      if (s1_rvalid && s1_rready) m_busy <= 1'b0;
    end
  end

  // ---------------- protocol monitors ----------------
  int s0_rr_bad = 0, s1_rr_bad = 0, s0_arv_cyc = 0, s1_arv_cyc = 0;
  logic [31:0] s0_last_addr = 32'd0, s1_last_addr = 32'd0;
  // Count rready-without-rvalid cycles, arvalid cycles and accepted addresses.
  always @(posedge clk) begin
    if (s0_rready && !s0_rvalid) s0_rr_bad <= s0_rr_bad + 1;
    if (s1_rready && !s1_rvalid) s1_rr_bad <= s1_rr_bad + 1;
    if (s0_arvalid) s0_arv_cyc <= s0_arv_cyc + 1;
    if (s1_arvalid) s1_arv_cyc <= s1_arv_cyc + 1;
    if (s0_arvalid && s0_arready) s0_last_addr <= s0_araddr;
    if (s1_arvalid && s1_arready) s1_last_addr <= s1_araddr;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One master read; rr_dly cycles of m_rready low once rvalid is seen.
  task automatic do_read(input logic [31:0] a, input int rr_dly,
                         output logic [31:0] d, output logic [1:0] r, output int lat);
    int n;
    @(negedge clk);
    m_araddr  = a;
    m_arvalid = 1'b1;
    m_rready  = 1'b0;
    n = 0;
    while (!m_arready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("arready_wait", m_arready, 1);
    @(posedge clk);
    #1;
    m_arvalid = 1'b0;
    m_araddr  = 32'd0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!m_rvalid && lat < 40);
    d = m_rdata;
    r = m_rresp;
    for (int k = 0; k < rr_dly; k++) begin
      @(negedge clk);
      chk("rvalid_hold", m_rvalid, 1);
      chk("rdata_hold", m_rdata, d);
    end
    m_rready = 1'b1;
    @(posedge clk);
    #1;
    m_rready = 1'b0;
    @(negedge clk);
    chk("post_rvalid", m_rvalid, 0);
    chk("post_arready", m_arready, 1);
    chk("post_rdata", m_rdata, 0);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [63:0] mtime;
    logic [31:0] mdata;
    logic [1:0]  mresp;
    int          ar_dly;
    int          rr_dly;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
    int          exp_sel;   // 0 = CLINT, 1 = memory, 2 = none
    int          exp_lat;   // negedges from AR handshake to first m_rvalid
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    int          lat;
    int          a0, a1, n;

    vecs[0]  = '{32'h0200_0000, 64'h40, 32'h0, 2'b00, 0, 0, 32'h0000_0001, 2'b00, 0, 2};
    vecs[1]  = '{32'h0200_000C, 64'hABCD_0000_0000_0000, 32'h0, 2'b00, 0, 2,
                 32'h02AF_3400, 2'b00, 0, 2};
    vecs[2]  = '{32'h8000_1000, 64'h0, 32'hDEAD_BEEF, 2'b00, 0, 0, 32'hDEAD_BEEF, 2'b00, 1, 6};
    vecs[3]  = '{32'h1000_0000, 64'h0, 32'h0, 2'b00, 0, 3, 32'h0, 2'b11, 2, 1};
    vecs[4]  = '{32'h87FF_FFFC, 64'h0, 32'h1234_5678, 2'b10, 0, 0, 32'h1234_5678, 2'b10, 1, 6};
    vecs[5]  = '{32'h8800_0000, 64'h0, 32'h0, 2'b00, 0, 0, 32'h0, 2'b11, 2, 1};
    vecs[6]  = '{32'h0201_0000, 64'h0, 32'h0, 2'b00, 0, 0, 32'h0, 2'b11, 2, 1};
    vecs[7]  = '{32'h0200_FFF8, 64'h1FC0, 32'h0, 2'b00, 0, 1, 32'h0000_007F, 2'b00, 0, 2};
    vecs[8]  = '{32'h8000_0004, 64'h0, 32'hA5A5_5A5A, 2'b00, 1, 0, 32'hA5A5_5A5A, 2'b00, 1, 7};
    vecs[9]  = '{32'h8000_0008, 64'h0, 32'h0F0F_F0F0, 2'b00, 2, 0, 32'h0F0F_F0F0, 2'b00, 1, 8};
    vecs[10] = '{32'h01FF_FFFC, 64'h0, 32'h0, 2'b00, 0, 0, 32'h0, 2'b11, 2, 1};

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_arready", m_arready, 1);
    chk("rst_rvalid", m_rvalid, 0);
    chk("rst_rdata", m_rdata, 0);
    chk("rst_rresp", m_rresp, 0);
    chk("rst_s0_arvalid", s0_arvalid, 0);
    chk("rst_s1_arvalid", s1_arvalid, 0);
    chk("rst_s0_rready", s0_rready, 0);
    chk("rst_s1_rready", s1_rready, 0);
    chk("rst_s0_araddr", s0_araddr, 0);
    chk("rst_s1_araddr", s1_araddr, 0);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven reads
    for (int i = 0; i < NV; i++) begin
      mtime      = vecs[i].mtime;
      mem_data   = vecs[i].mdata;
      mem_resp   = vecs[i].mresp;
      mem_ar_dly = vecs[i].ar_dly;
      a0 = s0_arv_cyc;
      a1 = s1_arv_cyc;
      do_read(vecs[i].addr, vecs[i].rr_dly, d, r, lat);
      $display("vector %0d addr=%h data=%h resp=%b lat=%0d", i, vecs[i].addr, d, r, lat);
      chk("rdata", d, vecs[i].exp_data);
      chk("rresp", r, vecs[i].exp_resp);
      chk("latency", lat, vecs[i].exp_lat);
      chk("s0_arvalid_cycles", s0_arv_cyc - a0, (vecs[i].exp_sel == 0) ? 1 : 0);
      chk("s1_arvalid_cycles", s1_arv_cyc - a1,
          (vecs[i].exp_sel == 1) ? vecs[i].ar_dly + 1 : 0);
      if (vecs[i].exp_sel == 0) chk("s0_araddr", s0_last_addr, vecs[i].addr);
      if (vecs[i].exp_sel == 1) chk("s1_araddr", s1_last_addr, vecs[i].addr);
    end

    // Timeout: memory accepts but never answers
    mem_ar_dly = 0;
    mem_hang   = 1'b1;
    do_read(32'h8000_2000, 0, d, r, lat);
    chk("tmo_rresp", r, 2'b10);
    chk("tmo_rdata", d, 0);
    chk("tmo_latency", lat, 9);
    chk("tmo_s1_arvalid", s1_arvalid, 0);
    // Late rvalid from the abandoned slave must be ignored.
    mem_hang = 1'b0;
    m_rready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("late_s1_rready", s1_rready, 0);
      chk("late_m_rvalid", m_rvalid, 0);
    end
    m_rready = 1'b0;
    mem_clr  = 1'b1;
    @(negedge clk);
    mem_clr = 1'b0;
    mtime   = 64'h80;
    do_read(32'h0200_0000, 0, d, r, lat);
    chk("after_tmo_rdata", d, 32'h2);
    chk("after_tmo_rresp", r, 2'b00);

    // Reset while a memory beat is waiting on m_rready
    mem_data = 32'hCAFE_F00D;
    @(negedge clk);
    m_araddr  = 32'h8000_0010;
    m_arvalid = 1'b1;
    @(posedge clk);
    #1;
    m_arvalid = 1'b0;
    n = 0;
    while (!m_rvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("pre_rst_rvalid", m_rvalid, 1);
    rst = 1'b1;
    #1;
    chk("midrst_rvalid", m_rvalid, 0);
    chk("midrst_arready", m_arready, 1);
    chk("midrst_rdata", m_rdata, 0);
    chk("midrst_s1_rready", s1_rready, 0);
    chk("midrst_s1_araddr", s1_araddr, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mem_data = 32'h0BAD_C0DE;
    do_read(32'h8000_0020, 0, d, r, lat);
    chk("after_rst_rdata", d, 32'h0BAD_C0DE);
    chk("after_rst_rresp", r, 2'b00);
    chk("after_rst_latency", lat, 6);

    chk("s0_rready_without_rvalid", s0_rr_bad, 0);
    chk("s1_rready_without_rvalid", s1_rr_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
